// File: rtl/spi_slave_if_pkg.sv
// Shared SPI definitions: mode encodings, FSM states and bit-order helper.
package spi_slave_if_pkg;

    // Mode value is {CPHA, CPOL}
    localparam logic [1:0] MODE0 = 2'd0;
    localparam logic [1:0] MODE1 = 2'd1;
    localparam logic [1:0] MODE2 = 2'd2;
    localparam logic [1:0] MODE3 = 2'd3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Pin synchronisers plus leading/trailing SCK edge detection relative to CPOL.
module spi_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic cpol_i,
    input  logic sck_i,
    input  logic ss_i,
    input  logic mosi_i,
    output logic ss_sync_o,
    output logic mosi_sync_o,
    output logic lead_o,
    output logic trail_o
);
    logic [2:0] sck_q;
    logic [1:0] ss_q;
    logic [1:0] mosi_q;

    // ss resets deasserted so a low pin after reset reads as a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_q  <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
        end else begin
            sck_q  <= {sck_q[1:0], sck_i};
            ss_q   <= {ss_q[0], ss_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    assign ss_sync_o   = ss_q[1];
    assign mosi_sync_o = mosi_q[1];
    assign lead_o      = (sck_q[1] != cpol_i) && (sck_q[2] == cpol_i);
    assign trail_o     = (sck_q[1] == cpol_i) && (sck_q[2] != cpol_i);

endmodule

// File: rtl/srl_fifo.sv
// Shift-register FIFO: newest entry at index 0, oldest at count-1.
module srl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      cnt_q, cnt_d;
    logic [AW-1:0]    rd_idx;
    logic             do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is accepted when a pop frees the head slot
    assign do_push = push_i && (!full_o || do_pop);
    assign rd_idx  = AW'(cnt_q - ONE);
    assign data_o  = mem_q[rd_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + ONE;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI target with bus-side TX holding byte and RX FIFO, oversampled in the clk domain.
module spi_slave_if
    import spi_slave_if_pkg::*;
#(
    parameter int         RX_DEPTH  = 4,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] din,
    input  logic        cmd,
    input  logic        wr,
    input  logic        rd,
    output logic [8:0]  dout,
    output logic        ack,
    output logic [3:0]  status,
    input  logic        spi_sck,
    input  logic        spi_ss,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe
);
    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic        lsb_q, lsb_d;
    logic        underrun_q, underrun_d, overrun_q, overrun_d;
    logic        hold_full_q, hold_full_d, first_q, first_d, ack_q;
    logic [7:0]  hold_q, hold_d, tx_shr_q, tx_shr_d, rx_shr_q, rx_shr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  tx_src, rx_byte, rx_data;
    logic        ss_sync, mosi_sync, lead, trail, cpha, cpol;
    logic        sample_edge, shift_edge, load, sample, shift, push;
    logic        rx_pop, rx_empty, rx_full;
    logic        unused_din;

    assign cpha        = mode_q[1];
    assign cpol        = mode_q[0];
    assign sample_edge = cpha ? trail : lead;
    assign shift_edge  = cpha ? lead : trail;
    assign unused_din  = ^din[10:8];

    spi_edge_sync u_sync (
        .clk         (clk),
        .rst         (rst),
        .cpol_i      (cpol),
        .sck_i       (spi_sck),
        .ss_i        (spi_ss),
        .mosi_i      (spi_mosi),
        .ss_sync_o   (ss_sync),
        .mosi_sync_o (mosi_sync),
        .lead_o      (lead),
        .trail_o     (trail)
    );

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (!ss_sync) state_d = S_SHIFT;
            S_SHIFT: if (ss_sync)  state_d = S_IDLE;
        endcase
    end

    // With CPHA=1 the first leading edge only opens the bit window; bit 7 is already on MISO
    always_comb begin : fsm_out
        load   = 1'b0;
        sample = 1'b0;
        shift  = 1'b0;
        unique case (state_q)
            S_IDLE: load = !ss_sync;
            S_SHIFT: begin
                if (!ss_sync) begin
                    sample = sample_edge;
                    if (shift_edge && !(first_q && cpha)) begin
                        if (bit_cnt_q == 3'd0) load = 1'b1;
                        else                   shift = 1'b1;
                    end
                end
            end
        endcase
    end

    assign push    = sample && (bit_cnt_q == 3'd7);
    assign rx_byte = {rx_shr_q[6:0], mosi_sync};
    assign rx_pop  = rd && !rx_empty;

    always_comb begin : datapath
        tx_src   = hold_full_q ? hold_q : IDLE_BYTE;
        tx_shr_d = tx_shr_q;
        if (load)       tx_shr_d = lsb_q ? bitrev8(tx_src) : tx_src;
        else if (shift) tx_shr_d = {tx_shr_q[6:0], 1'b0};

        rx_shr_d = sample ? rx_byte : rx_shr_q;

        bit_cnt_d = bit_cnt_q;
        if (ss_sync || state_q == S_IDLE) bit_cnt_d = '0;
        else if (sample)                  bit_cnt_d = bit_cnt_q + 3'd1;

        first_d = first_q;
        if (state_q == S_IDLE) first_d = 1'b1;
        else if (shift_edge)   first_d = 1'b0;

        // Load consumes the old holding byte before a same-cycle write refills it
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (load) hold_full_d = 1'b0;
        if (wr && (!hold_full_q || load)) begin
            hold_d      = din[7:0];
            hold_full_d = 1'b1;
        end

        mode_d = cmd ? din[1:0] : mode_q;
        lsb_d  = cmd ? din[2] : lsb_q;

        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        if (cmd && din[3]) begin
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (load && !hold_full_q)        underrun_d = 1'b1;
        if (push && rx_full && !rx_pop) overrun_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= MODE0;
            lsb_q       <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
            hold_full_q <= 1'b0;
            first_q     <= 1'b1;
            bit_cnt_q   <= '0;
            tx_shr_q    <= 8'hFF;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            lsb_q       <= lsb_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
            hold_full_q <= hold_full_d;
            first_q     <= first_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shr_q    <= tx_shr_d;
            ack_q       <= wr | rd | cmd;
        end
    end

    always_ff @(posedge clk) begin
        hold_q   <= hold_d;
        rx_shr_q <= rx_shr_d;
    end

    srl_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (lsb_q ? bitrev8(rx_byte) : rx_byte),
        .pop_i   (rx_pop),
        .data_o  (rx_data),
        .empty_o (rx_empty),
        .full_o  (rx_full)
    );

    assign dout        = rx_pop ? {1'b0, rx_data} : {1'b1, 8'h00};
    assign ack         = ack_q;
    assign status      = {underrun_q, overrun_q, hold_full_q, !rx_empty};
    assign spi_miso    = tx_shr_q[7];
    assign spi_miso_oe = !ss_sync;

endmodule
